charram_dram_ctrl: RTL

- Initiator-side sequencer for the 4416-style character RAM (16k x 4).
- Arbitrates a video pixel-fetch port and a CPU port.
- Multiplexes a 14-bit linear address into row/column phases and generates /RAS, /CAS, /WR and /RD with the single-MCLK phase spacing the DRAM model samples on.
- Returns read data or write acknowledgement to the granted requester.

---
 rtl/charram_dram_pkg.sv | 38 +++
 rtl/charram_dram_arb.sv | 44 ++++
 rtl/charram_dram_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/charram_dram_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | charram_dram_pkg : shared types/fields for the 4416 char-RAM sequencer  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package charram_dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DATA = 3'd4,
    ST_PRE  = 3'd5
  } state_e;

  typedef enum logic {
    SRC_VID = 1'b0,
    SRC_CPU = 1'b1
  } src_e;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned ROW_LSB = 0;
  localparam int unsigned ROW_W   = 8;
  localparam int unsigned COL_LSB = 8;
  localparam int unsigned COL_W   = 6;

  function automatic logic [7:0] row_phase(input logic [ADDR_W-1:0] a);
    return a[ROW_LSB +: ROW_W];
  endfunction

  // The column rides on DRAM address bits [6:1]; bits 7 and 0 stay low.
  function automatic logic [7:0] col_phase(input logic [ADDR_W-1:0] a);
    return {1'b0, a[COL_LSB +: COL_W], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/charram_dram_arb.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | charram_dram_arb : video-priority arbiter with one-skip CPU fairness    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module charram_dram_arb
  import charram_dram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic vid_req_i,
  input  logic cpu_req_i,
  output logic grant_o,
  output src_e src_o
);

  logic skip_q, skip_d;

  always_comb begin
    grant_o = 1'b0;
    src_o   = SRC_VID;
    skip_d  = skip_q;
    if (en_i) begin
      // CPU wins when it already yielded once, or when video is absent.
      if (cpu_req_i && (skip_q || !vid_req_i)) begin
        grant_o = 1'b1;
        src_o   = SRC_CPU;
        skip_d  = 1'b0;
      end else if (vid_req_i) begin
        grant_o = 1'b1;
        src_o   = SRC_VID;
        if (cpu_req_i) skip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end

endmodule
`default_nettype wire

// File: rtl/charram_dram_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | charram_dram_ctrl : RAS/CAS sequencer for the 16k x 4 character RAM     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module charram_dram_ctrl
  import charram_dram_pkg::*;
#(
  parameter int unsigned PRE_CYCLES = 1
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic [3:0]  o_VID_DATA,
  output logic        o_VID_VALID,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_WDATA,
  output logic [3:0]  o_CPU_RDATA,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_DRAM_ADDR,
  output logic [3:0]  o_DRAM_DIN,
  input  logic [3:0]  i_DRAM_DOUT,
  output logic        o_DRAM_RAS_n,
  output logic        o_DRAM_CAS_n,
  output logic        o_DRAM_WR_n,
  output logic        o_DRAM_RD_n,
  output logic        o_BUSY
);

  state_e       state_q, state_d;
  logic [2:0]   pre_cnt_q, pre_cnt_d;
  logic [13:0]  acc_addr_q, acc_addr_d;
  logic         acc_wr_q, acc_wr_d;
  src_e         acc_src_q, acc_src_d;

  logic [7:0]   dram_addr_q, dram_addr_d;
  logic [3:0]   dram_din_q, dram_din_d;
  logic         ras_n_q, ras_n_d, cas_n_q, cas_n_d;
  logic         wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [3:0]   vid_data_q, vid_data_d, cpu_rdata_q, cpu_rdata_d;
  logic         vid_valid_q, vid_valid_d, cpu_ack_q, cpu_ack_d;
  logic         busy_q, busy_d;

  logic         arb_grant;
  src_e         arb_src;
  logic [13:0]  grant_addr;

  charram_dram_arb u_arb (
    .clk_i     (i_MCLK),
    .rst_i     (i_RST),
    .en_i      (state_q == ST_IDLE),
    .vid_req_i (i_VID_REQ),
    .cpu_req_i (i_CPU_REQ),
    .grant_o   (arb_grant),
    .src_o     (arb_src)
  );

  assign grant_addr = (arb_src == SRC_CPU) ? i_CPU_ADDR : i_VID_ADDR;

  // Output registers are loaded with the values of the state being entered,
  // so every strobe/address is stable for the whole cycle of its state.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    acc_addr_d  = acc_addr_q;
    acc_wr_d    = acc_wr_q;
    acc_src_d   = acc_src_q;
    dram_addr_d = dram_addr_q;
    dram_din_d  = dram_din_q;
    ras_n_d     = 1'b1;
    cas_n_d     = 1'b1;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_grant) begin
          state_d     = ST_ROW;
          acc_addr_d  = grant_addr;
          acc_src_d   = arb_src;
          acc_wr_d    = (arb_src == SRC_CPU) && i_CPU_WR;
          dram_addr_d = row_phase(grant_addr);
          if (arb_src == SRC_CPU) dram_din_d = i_CPU_WDATA;
          ras_n_d     = 1'b0;
        end
      end
      ST_ROW: begin
        state_d     = ST_COL;
        dram_addr_d = col_phase(acc_addr_q);
        ras_n_d     = 1'b0;
        cas_n_d     = 1'b0;
      end
      ST_COL: begin
        state_d = ST_ACC;
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        wr_n_d  = !acc_wr_q;
        rd_n_d  = acc_wr_q;
      end
      ST_ACC: begin
        state_d = ST_DATA;
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
      end
      ST_DATA: begin
        state_d   = ST_PRE;
        pre_cnt_d = 3'(PRE_CYCLES - 1);
        if (!acc_wr_q) begin
          if (acc_src_q == SRC_VID) vid_data_d  = i_DRAM_DOUT;
          else                      cpu_rdata_d = i_DRAM_DOUT;
        end
        vid_valid_d = (acc_src_q == SRC_VID);
        cpu_ack_d   = (acc_src_q == SRC_CPU);
      end
      ST_PRE: begin
        if (pre_cnt_q == 3'd0) state_d = ST_IDLE;
        else                   pre_cnt_d = pre_cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= 3'd0;
      acc_addr_q  <= '0;
      acc_wr_q    <= 1'b0;
      acc_src_q   <= SRC_VID;
      dram_addr_q <= '0;
      dram_din_q  <= '0;
      ras_n_q     <= 1'b1;
      cas_n_q     <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      acc_addr_q  <= acc_addr_d;
      acc_wr_q    <= acc_wr_d;
      acc_src_q   <= acc_src_d;
      dram_addr_q <= dram_addr_d;
      dram_din_q  <= dram_din_d;
      ras_n_q     <= ras_n_d;
      cas_n_q     <= cas_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_valid_q <= vid_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign o_VID_DATA   = vid_data_q;
  assign o_VID_VALID  = vid_valid_q;
  assign o_CPU_RDATA  = cpu_rdata_q;
  assign o_CPU_ACK    = cpu_ack_q;
  assign o_DRAM_ADDR  = dram_addr_q;
  assign o_DRAM_DIN   = dram_din_q;
  assign o_DRAM_RAS_n = ras_n_q;
  assign o_DRAM_CAS_n = cas_n_q;
  assign o_DRAM_WR_n  = wr_n_q;
  assign o_DRAM_RD_n  = rd_n_q;
  assign o_BUSY       = busy_q;

endmodule
`default_nettype wire
